// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register of a 5-stage MIPS pipeline.
// Owns the PC, fetches over a req/ack handshake with one fetch outstanding at a time,
// applies ID-stage redirects (branch, jump, flush) and honours hazard-unit stalls.
// Optional feature macro IF_PERF_CNT_EN adds fetchCount / squashCount performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [1:0]  pcSrc,
    input  logic        IFFlush,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] squashCount
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_FULL   = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        ack_v;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;

    // Decode handshake qualifiers and the redirect target.
    always_comb begin
        ack_v    = imemAck & req_q;
        redirect = (pcSrc == 2'd1) | (pcSrc == 2'd2) | IFFlush;
        pc_plus4 = pc_q + 32'd4;
        case (pcSrc)
            2'd1:    redirect_target = branchTarget & 32'hFFFF_FFFC;
            2'd2:    redirect_target = {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00};
            default: redirect_target = pc_q;  // flush-only refetches the current pc
        endcase
    end

    // Next-state, next-PC and IF/ID update; redirect beats stall beats normal flow.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;

        if (redirect) begin
            pc_d          = redirect_target;
            if_id_instr_d = 32'd0;
            if_id_valid_d = 1'b0;
            buf_instr_d   = 32'd0;
            buf_pc4_d     = 32'd0;
            case (state_q)
                ST_FETCH: begin
                    // An outstanding fetch that has not returned must be drained.
                    if (req_q && !ack_v) begin
                        state_d = ST_SQUASH;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_SQUASH: begin
                    if (ack_v) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_SQUASH;
                    end
                end
                ST_FULL:  state_d = ST_FETCH;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (ack_v) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            // ID cannot accept: park the instruction until stall drops.
                            buf_instr_d = imemRdata;
                            buf_pc4_d   = pc_plus4;
                            state_d     = ST_FULL;
                        end else begin
                            if_id_instr_d = imemRdata;
                            if_id_pc4_d   = pc_plus4;
                            if_id_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_instr_d = 32'd0;
                        if_id_valid_d = 1'b0;
                    end else begin
                        if_id_valid_d = if_id_valid_q;
                    end
                end
                ST_FULL: begin
                    if (!stall) begin
                        if_id_instr_d = buf_instr_q;
                        if_id_pc4_d   = buf_pc4_q;
                        if_id_valid_d = 1'b1;
                        buf_instr_d   = 32'd0;
                        buf_pc4_d     = 32'd0;
                        state_d       = ST_FETCH;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SQUASH: begin
                    if (ack_v) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_SQUASH;
                    end
                    if (!stall) begin
                        if_id_instr_d = 32'd0;
                        if_id_valid_d = 1'b0;
                    end else begin
                        if_id_valid_d = if_id_valid_q;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end

        // Request whenever not parked; address frozen while a request is outstanding.
        req_d = (state_d != ST_FULL);
        if (req_q && !ack_v) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            addr_q        <= RESET_PC;
            buf_instr_q   <= 32'd0;
            buf_pc4_q     <= 32'd0;
            if_id_instr_q <= 32'd0;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc4_q     <= buf_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imemReq     = req_q;
    assign imemAddr    = addr_q;
    assign ifIdInstr   = if_id_instr_q;
    assign ifIdPcPlus4 = if_id_pc4_q;
    assign ifIdValid   = if_id_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;
    logic        fetch_inc;
    logic        squash_inc;

    // Count accepted acks and discarded work (dropped acks, cleared buffer).
    always_comb begin
        fetch_inc  = ack_v && (state_q == ST_FETCH) && !redirect;
        squash_inc = (ack_v && ((state_q == ST_SQUASH) || ((state_q == ST_FETCH) && redirect)))
                   || ((state_q == ST_FULL) && redirect);
        fetch_cnt_d  = fetch_cnt_q + {31'd0, fetch_inc};
        squash_cnt_d = squash_cnt_q + {31'd0, squash_inc};
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign fetchCount  = fetch_cnt_q;
    assign squashCount = squash_cnt_q;
`endif

endmodule
